// File: rtl/ypc_exec_sequencer.sv
// ---------------------------------------------------------------------------
// ypc_exec_sequencer
//
// Multi-cycle control FSM for the YPC core datapath. It fetches one
// instruction at a time over a valid/ready request port and a
// variable-latency response port. It holds the instruction in inst_q so the
// combinational decoder can settle, then strobes the ALU and the regfile
// write. Finally it advances the PC and counts retirements. Execution stops
// on ebreak (halt) or when a fetch response never arrives (fault).
//
// Ports
//   clk             clock, all state changes on posedge
//   reset           asynchronous, active-low reset
//   run_en          permission to start / continue fetching (IDLE, WB only)
//   imem_req_valid  fetch request (high in FETCH)
//   imem_req_addr   fetch address, always equal to pc
//   imem_req_ready  memory accepts the request
//   imem_rsp_valid  instruction data valid (used only in WAIT)
//   imem_rsp_inst   instruction data
//   inst_q          latched instruction feeding the decoder
//   dec_isbreak     decoder: inst_q is ebreak
//   dec_aluop       decoder: inst_q is addi-class
//   dec_regwen      decoder: inst_q writes rd
//   alu_en          one-cycle ALU strobe (EXEC)
//   rf_wen          one-cycle regfile write strobe (WB)
//   pc              current PC
//   retired         retired-instruction counter (wraps)
//   halt            sticky, ebreak reached
//   fault           sticky, fetch response timeout
// ---------------------------------------------------------------------------
module ypc_exec_sequencer #(
   parameter int unsigned       XLEN     = 32,
   parameter logic [XLEN-1:0]   RESET_PC = '0,
   parameter int unsigned       TIMEOUT  = 255
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            run_en,
   output logic            imem_req_valid,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_req_ready,
   input  logic            imem_rsp_valid,
   input  logic [31:0]     imem_rsp_inst,
   output logic [31:0]     inst_q,
   input  logic            dec_isbreak,
   input  logic            dec_aluop,
   input  logic            dec_regwen,
   output logic            alu_en,
   output logic            rf_wen,
   output logic [XLEN-1:0] pc,
   output logic [31:0]     retired,
   output logic            halt,
   output logic            fault
);

   // Counter just wide enough to reach TIMEOUT; with TIMEOUT=0 it simply
   // wraps and is never compared.
   localparam int unsigned      CNT_W      = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] TIMEOUT_V  = CNT_W'(TIMEOUT);
   localparam logic             TIMEOUT_EN = (TIMEOUT != 0);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_WAIT,
      S_DECODE,
      S_EXEC,
      S_WB,
      S_HALT,
      S_FAULT
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] wait_cnt;
   logic [CNT_W-1:0] wait_cnt_inc;
   logic             wait_expired;

   assign wait_cnt_inc  = wait_cnt + CNT_W'(1);
   // Expiry looks at the incremented value so FAULT is entered after exactly
   // TIMEOUT response-less WAIT cycles.
   assign wait_expired  = TIMEOUT_EN && (wait_cnt_inc == TIMEOUT_V);
   assign imem_req_addr = pc;

   // ---- next state and Moore strobes ----
   always_comb begin
      state_nxt      = state;
      imem_req_valid = 1'b0;
      alu_en         = 1'b0;
      rf_wen         = 1'b0;
      halt           = 1'b0;
      fault          = 1'b0;
      case (state)
         S_IDLE: begin
            if (run_en) state_nxt = S_FETCH;
         end
         S_FETCH: begin
            imem_req_valid = 1'b1;
            if (imem_req_ready) state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (imem_rsp_valid)    state_nxt = S_DECODE;
            else if (wait_expired) state_nxt = S_FAULT;
         end
         S_DECODE: begin
            state_nxt = S_EXEC;
         end
         S_EXEC: begin
            // ebreak suppresses both strobes and leaves pc untouched.
            if (dec_isbreak) begin
               state_nxt = S_HALT;
            end else begin
               alu_en    = dec_aluop;
               state_nxt = S_WB;
            end
         end
         S_WB: begin
            rf_wen    = dec_aluop & dec_regwen;
            state_nxt = run_en ? S_FETCH : S_IDLE;
         end
         S_HALT: begin
            halt = 1'b1;
         end
         S_FAULT: begin
            fault = 1'b1;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // ---- state, instruction latch, pc, counters ----
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= S_IDLE;
         pc       <= RESET_PC;
         inst_q   <= '0;
         retired  <= '0;
         wait_cnt <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            S_FETCH: begin
               if (imem_req_ready) wait_cnt <= '0;
            end
            S_WAIT: begin
               if (imem_rsp_valid) inst_q   <= imem_rsp_inst;
               else                wait_cnt <= wait_cnt_inc;
            end
            S_WB: begin
               pc      <= pc + XLEN'(4);
               retired <= retired + 32'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ypc_exec_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ypc_exec_sequencer
//
// Two sequencer instances share the memory and decoder stimulus.
// dut_a uses RESET_PC=0 and TIMEOUT=4. dut_b uses RESET_PC=FFFF_FFFC.
// sel picks which instance is live, and the other one is held in reset.
// A memory responder serves fetches from a small ROM. When it delivers an
// instruction that must write rd, it pushes the fetch address to a
// scoreboard. The monitor pops that entry on each rf_wen and compares it with
// pc.
// ---------------------------------------------------------------------------
module tb_ypc_exec_sequencer;

   localparam logic [31:0] ADDI_X1_5 = 32'h0050_0093;  // addi x1,x0,5
   localparam logic [31:0] ADDI_X2_7 = 32'h0070_0113;  // addi x2,x0,7
   localparam logic [31:0] EBREAK    = 32'h0010_0073;
   localparam logic [31:0] NOP       = 32'h0000_0013;  // addi x0,x0,0

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_a, rst_b, sel;
   logic        run_en, req_ready, rsp_valid;
   logic [31:0] rsp_inst;
   logic        dec_isbreak, dec_aluop, dec_regwen;

   logic        req_valid_a, alu_en_a, rf_wen_a, halt_a, fault_a;
   logic [31:0] addr_a, inst_q_a, pc_a, retired_a;
   logic        req_valid_b, alu_en_b, rf_wen_b, halt_b, fault_b;
   logic [31:0] addr_b, inst_q_b, pc_b, retired_b;

   // view of the live instance
   logic        rst_m, req_valid, alu_en, rf_wen, halt, fault;
   logic [31:0] addr, inst_q, pc, retired;
   assign rst_m     = sel ? rst_b       : rst_a;
   assign req_valid = sel ? req_valid_b : req_valid_a;
   assign alu_en    = sel ? alu_en_b    : alu_en_a;
   assign rf_wen    = sel ? rf_wen_b    : rf_wen_a;
   assign halt      = sel ? halt_b      : halt_a;
   assign fault     = sel ? fault_b     : fault_a;
   assign addr      = sel ? addr_b      : addr_a;
   assign inst_q    = sel ? inst_q_b    : inst_q_a;
   assign pc        = sel ? pc_b        : pc_a;
   assign retired   = sel ? retired_b   : retired_a;

   // decoder model
   assign dec_isbreak = (inst_q == EBREAK);
   assign dec_aluop   = (inst_q[6:0] == 7'h13) && (inst_q[14:12] == 3'b000);
   assign dec_regwen  = (inst_q[11:7] != 5'd0);

   ypc_exec_sequencer #(.XLEN(32), .RESET_PC(32'h0), .TIMEOUT(4)) dut_a (
      .clk(clk), .reset(rst_a), .run_en(run_en),
      .imem_req_valid(req_valid_a), .imem_req_addr(addr_a), .imem_req_ready(req_ready),
      .imem_rsp_valid(rsp_valid), .imem_rsp_inst(rsp_inst), .inst_q(inst_q_a),
      .dec_isbreak(dec_isbreak), .dec_aluop(dec_aluop), .dec_regwen(dec_regwen),
      .alu_en(alu_en_a), .rf_wen(rf_wen_a), .pc(pc_a), .retired(retired_a),
      .halt(halt_a), .fault(fault_a));

   ypc_exec_sequencer #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC), .TIMEOUT(255)) dut_b (
      .clk(clk), .reset(rst_b), .run_en(run_en),
      .imem_req_valid(req_valid_b), .imem_req_addr(addr_b), .imem_req_ready(req_ready),
      .imem_rsp_valid(rsp_valid), .imem_rsp_inst(rsp_inst), .inst_q(inst_q_b),
      .dec_isbreak(dec_isbreak), .dec_aluop(dec_aluop), .dec_regwen(dec_regwen),
      .alu_en(alu_en_b), .rf_wen(rf_wen_b), .pc(pc_b), .retired(retired_b),
      .halt(halt_b), .fault(fault_b));

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   // cycles since reset release (0 = first cycle, in IDLE)
   int cyc = 0;
   always @(posedge clk) cyc <= rst_m ? cyc + 1 : 0;

   // memory responder
   logic [31:0] rom [16];
   logic [31:0] sb [$];
   bit          pend, withhold, stall_seen;
   int          dly, stall_left;
   logic [31:0] paddr, stall_addr;

   initial begin
      req_ready = 1'b1;
      rsp_valid = 1'b0;
      rsp_inst  = '0;
      forever begin
         @(negedge clk);
         rsp_valid = 1'b0;
         if (rst_m && pend) begin
            if (dly == 0) begin
               rsp_valid = 1'b1;
               rsp_inst  = rom[paddr[5:2]];
               if (rsp_inst[6:0] == 7'h13 && rsp_inst[14:12] == 3'b000 && rsp_inst[11:7] != 5'd0)
                  sb.push_back(paddr);
               pend = 1'b0;
            end else begin
               dly--;
            end
         end
         req_ready = 1'b1;
         if (rst_m && req_valid) begin
            if (stall_left > 0) begin
               req_ready = 1'b0;
               if (stall_seen) check("stall_addr_hold", addr, stall_addr);
               stall_seen = 1'b1;
               stall_addr = addr;
               stall_left--;
            end else begin
               pend  = 1'b1;
               paddr = addr;
               dly   = withhold ? 100000 : 0;
            end
         end
      end
   end

   // monitor
   int n_alu, n_wen, first_wen, first_halt, first_fault;

   initial begin
      forever begin
         @(negedge clk);
         if (rst_m) begin
            if (alu_en) n_alu++;
            if (rf_wen) begin
               n_wen++;
               if (first_wen < 0) first_wen = cyc;
               if (sb.size() == 0) check("wb_sb_empty", 32'd1, 32'd0);
               else                check("wb_pc", pc, sb.pop_front());
            end
            if (halt  && first_halt  < 0) first_halt  = cyc;
            if (fault && first_fault < 0) first_fault = cyc;
            if (alu_en || rf_wen || req_valid)
               check("strobe_onehot", 32'(int'(alu_en) + int'(rf_wen) + int'(req_valid)), 32'd1);
         end
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic clear_counts();
      n_alu = 0; n_wen = 0; first_wen = -1; first_halt = -1; first_fault = -1;
   endtask

   task automatic reset_all(input bit s);
      step();
      sel = s; rst_a = 1'b0; rst_b = 1'b0; run_en = 1'b0;
      pend = 1'b0; withhold = 1'b0; stall_left = 0; stall_seen = 1'b0;
      sb.delete();
      foreach (rom[i]) rom[i] = NOP;
      repeat (2) step();
      clear_counts();
   endtask

   task automatic release_rst();
      if (sel) rst_b = 1'b1;
      else     rst_a = 1'b1;
   endtask

   task automatic wait_cyc(input int n);
      for (int i = 0; i < 1000 && cyc < n; i++) step();
   endtask

   task automatic wait_done(input string tag);
      for (int i = 0; i < 200 && !(halt || fault); i++) step();
      check(tag, 32'(halt || fault), 32'd1);
   endtask

   initial begin
      sel = 1'b0; rst_a = 1'b0; rst_b = 1'b0; run_en = 1'b0;
      clear_counts();

      // ---- reset values ----
      reset_all(1'b0);
      check("rst_pc",      pc,                32'h0);
      check("rst_addr",    addr,              32'h0);
      check("rst_retired", retired,           32'h0);
      check("rst_inst_q",  inst_q,            32'h0);
      check("rst_strobes", {29'd0, req_valid, alu_en, rf_wen}, 32'h0);
      check("rst_flags",   {30'd0, halt, fault}, 32'h0);

      // ---- addi then ebreak, 0-wait memory ----
      reset_all(1'b0);
      rom[0] = ADDI_X1_5; rom[1] = EBREAK;
      run_en = 1'b1;
      release_rst();
      wait_done("t1_done");
      check("t1_wen_cycle",  32'(first_wen), 32'd5);
      // ebreak reaches EXEC at cycle 9; halt is visible from the next cycle
      check("t1_halt_cycle", 32'(first_halt), 32'd10);
      check("t1_n_wen",      32'(n_wen), 32'd1);
      check("t1_n_alu",      32'(n_alu), 32'd1);
      check("t1_pc",         pc, 32'd4);
      check("t1_retired",    retired, 32'd1);
      repeat (3) step();
      check("t1_halt_sticky", {30'd0, halt, fault}, 32'h2);
      check("t1_no_fetch",   32'(req_valid), 32'd0);

      // ---- request stalled 3 cycles ----
      reset_all(1'b0);
      rom[0] = ADDI_X1_5; rom[1] = EBREAK;
      stall_left = 3;
      run_en = 1'b1;
      release_rst();
      wait_done("t2_done");
      check("t2_stall_used", 32'(stall_left), 32'd0);
      check("t2_wen_cycle",  32'(first_wen), 32'd8);
      check("t2_halt_cycle", 32'(first_halt), 32'd13);
      check("t2_pc",         pc, 32'd4);

      // ---- response withheld, TIMEOUT=4 ----
      reset_all(1'b0);
      rom[0] = ADDI_X1_5;
      withhold = 1'b1;
      run_en = 1'b1;
      release_rst();
      wait_done("t3_done");
      check("t3_fault_cycle", 32'(first_fault), 32'd6);
      check("t3_flags",       {30'd0, halt, fault}, 32'h1);
      check("t3_n_wen",       32'(n_wen), 32'd0);
      check("t3_pc",          pc, 32'd0);
      check("t3_retired",     retired, 32'd0);

      // ---- run_en dropped during EXEC ----
      reset_all(1'b0);
      rom[0] = ADDI_X1_5; rom[1] = ADDI_X2_7; rom[2] = EBREAK;
      run_en = 1'b1;
      release_rst();
      wait_cyc(4);
      check("t4_in_exec", 32'(alu_en), 32'd1);
      run_en = 1'b0;
      wait_cyc(8);
      check("t4_idle_noreq", 32'(req_valid), 32'd0);
      check("t4_idle_pc",    pc, 32'd4);
      check("t4_idle_ret",   retired, 32'd1);
      check("t4_idle_wen",   32'(n_wen), 32'd1);
      run_en = 1'b1;
      step();
      check("t4_resume_req",  32'(req_valid), 32'd1);
      check("t4_resume_addr", addr, 32'd4);
      wait_done("t4_done");
      check("t4_pc",      pc, 32'd8);
      check("t4_retired", retired, 32'd2);
      check("t4_n_wen",   32'(n_wen), 32'd2);

      // ---- reset pulled in EXEC ----
      reset_all(1'b0);
      rom[0] = ADDI_X1_5; rom[1] = EBREAK;
      run_en = 1'b1;
      release_rst();
      wait_cyc(4);
      check("t5_in_exec", 32'(alu_en), 32'd1);
      rst_a = 1'b0;
      #1;
      check("t5_strobes", {29'd0, req_valid, alu_en, rf_wen}, 32'h0);
      check("t5_inst_q",  inst_q, 32'h0);
      check("t5_pc",      pc, 32'h0);
      check("t5_flags",   {30'd0, halt, fault}, 32'h0);
      clear_counts();
      sb.delete();
      pend = 1'b0;
      repeat (3) step();
      check("t5_no_wen",  32'(rf_wen), 32'd0);
      check("t5_retired", retired, 32'h0);

      // ---- pc wrap with RESET_PC = FFFF_FFFC ----
      reset_all(1'b1);
      rom[15] = ADDI_X1_5; rom[0] = EBREAK;
      check("t6_rst_pc", pc, 32'hFFFF_FFFC);
      run_en = 1'b1;
      release_rst();
      wait_done("t6_done");
      check("t6_wen_cycle", 32'(first_wen), 32'd5);
      check("t6_pc",        pc, 32'h0);
      check("t6_retired",   retired, 32'd1);
      check("t6_halt",      32'(halt), 32'd1);

      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
